vram_scheduler: RTL and testbench
=================================

# vram_scheduler

Frame-level scheduler and per-cycle arbiter for the double-buffered video RAM shared between the display path and the Julia-set renderer. It sits between the sync generator, the renderer and a single-port synchronous RAM. Display reads are issued once per pixel during active video and always win. Renderer writes fill the back bank in the remaining cycles, and banks swap at vertical sync once a frame is complete.

## Interface
- `ADDR_W`, 19: pixel address width per bank; RAM address is `ADDR_W+1` bits, with the MSB selecting the bank.
- `DATA_W`, 8: pixel width.
- `NPIX`, 307200: pixels per frame (640×480); the display address wraps at this value.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `PCK`  in  1  pixel clock level from the sync generator, synchronous to `CLK`, high and low phases each ≥2 `CLK` cycles.
- `ENABLE_MEM`  in  1  high during blanking, low during active video.
- `VS`  in  1  vertical sync level.
- `REN_REQ`  in  1  renderer write request.
- `REN_ADDR`  in  ADDR_W  renderer pixel address.
- `REN_WDATA`  in  DATA_W  renderer pixel data.
- `REN_ACK`  out  1  one-cycle write accept.
- `REN_DONE`  in  1  one-cycle pulse: renderer finished the frame.
- `FRAME_START`  out  1  one-cycle pulse: start rendering into the back bank.
- `MEM_EN`  out  1  RAM access enable.
- `MEM_WE`  out  1  RAM write enable.
- `MEM_ADDR`  out  ADDR_W+1  RAM address.
- `MEM_WDATA`  out  DATA_W  RAM write data.
- `MEM_RDATA`  in  DATA_W  RAM read data, valid one cycle after a read access.
- `PIX_DATA`  out  DATA_W  last pixel read for display.
- `PIX_VALID`  out  1  one-cycle pulse when `PIX_DATA` updates.
- `DISP_BANK`  out  1  bank currently displayed; the renderer writes `~DISP_BANK`.
- `FRAME_DROP`  out  8  count of VS events missed by the renderer; saturates at 255.

## Operation
**Edge detection**
- The block registers `pck_q` and `vs_q`.
- `pck_rise = PCK & ~pck_q`.
- `vs_rise = VS & ~vs_q`.

**Arbitration.** Memory outputs are registered; the decision made in cycle N drives the memory in cycle N+1.
- Priority 1: `pck_rise & ~ENABLE_MEM` issues a display read: `MEM_EN=1`, `MEM_WE=0`, `MEM_ADDR={DISP_BANK, rd_addr}`.
- Priority 2: `REN_REQ & ~REN_ACK` issues a write: `MEM_EN=1`, `MEM_WE=1`, `MEM_ADDR={~DISP_BANK, REN_ADDR}`, `MEM_WDATA=REN_WDATA`, with `REN_ACK=1` in the same cycle.
- Otherwise `MEM_EN=0` and `MEM_WE=0`.

**Renderer handshake**
- The renderer holds `REN_REQ`, `REN_ADDR` and `REN_WDATA` stable until `REN_ACK`.
- No grant is made in a cycle where `REN_ACK` is high, so at most one write occurs per 2 cycles.

**Display address**
- `rd_addr` increments after each issued read.
- It wraps from `NPIX-1` to 0.
- It clears to 0 on `vs_rise`; the clear takes precedence over the increment.

**Read return**
- A read issued in cycle N+1 produces `PIX_DATA<=MEM_RDATA` at the end of N+2.
- `PIX_VALID` is high in N+3 for one cycle.

**Frame FSM**
- IDLE → START on `vs_rise`.
- START: `FRAME_START=1` for one cycle → RENDER.
- RENDER → WAIT on `REN_DONE`.
- RENDER on `vs_rise` without `REN_DONE`: stay in RENDER, no swap, `FRAME_DROP` +1 (saturating).
- RENDER with `REN_DONE` and `vs_rise` in the same cycle: toggle `DISP_BANK` → START (counts as done, no drop).
- WAIT on `vs_rise`: toggle `DISP_BANK` → START.
- `REN_DONE` outside RENDER is ignored.

## Timing
- **Reset values:** every output 0; FSM in IDLE; `rd_addr=0`; `pck_q=vs_q=0`.
- **Reset mid-operation:** an in-flight read, write or frame is abandoned; no `PIX_VALID` is produced for reads issued before reset.
- **Display read latency:** `pck_rise` in cycle N gives `MEM_EN` in N+1 and `PIX_VALID` in N+3.
- **Write latency:** `REN_REQ` sampled in N (slot free) gives `REN_ACK` and the memory write both in N+1.
- **Collision:** `pck_rise` during active video and `REN_REQ` in the same cycle; the read wins, and the write is granted at the earliest one cycle later.
- **Blanking:** with `ENABLE_MEM=1` no reads are issued; all slots are available to writes.
- **Swap timing:** `DISP_BANK` toggles in the cycle after `vs_rise`, the same cycle `rd_addr` reads 0; `FRAME_START` is in the following cycle.

## Test plan
- **Reset:** assert `RST` mid-stream → all outputs 0 immediately; after release, FSM waits for the first `VS` rise before `FRAME_START`.
- **Display read:** `ENABLE_MEM=0`, `PCK` rises at cycle 10 → `MEM_EN=1`, `MEM_WE=0`, `MEM_ADDR={0,0}` at 11; RAM returns 0x5A → `PIX_DATA=0x5A`, `PIX_VALID` at 13; the next pixel reads address 1.
- **Collision:** `REN_REQ` (addr 0x100, data 0xC3) in the same cycle as `pck_rise` during active video → read at N+1, `REN_ACK` and write `{1,0x100}`=0xC3 at N+2; exactly one write, even with `REN_REQ` held through the ACK cycle.
- **Normal frame:** `REN_DONE` then `vs_rise` → `DISP_BANK` 0→1, `rd_addr` 0, `FRAME_START` pulse; subsequent writes target bank 0.
- **Overrun:** 3 `vs_rise` events without `REN_DONE` → `FRAME_DROP=3`, `DISP_BANK` unchanged; then `REN_DONE` and `vs_rise` in the same cycle → swap, `FRAME_DROP` stays 3.
- **Saturation and wrap:** 300 missed frames → `FRAME_DROP=255`; `NPIX` reads without VS → `rd_addr` wraps to 0.

Source files
------------

// File: rtl/vram_scheduler.sv
// Double-buffered video RAM scheduler: display reads win each pixel slot,
// renderer writes fill the back bank, and banks swap at VS once a frame is done.
module vram_scheduler #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int NPIX   = 307200
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PCK,
    input  logic              ENABLE_MEM,
    input  logic              VS,
    input  logic              REN_REQ,
    input  logic [ADDR_W-1:0] REN_ADDR,
    input  logic [DATA_W-1:0] REN_WDATA,
    output logic              REN_ACK,
    input  logic              REN_DONE,
    output logic              FRAME_START,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W:0]   MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID,
    output logic              DISP_BANK,
    output logic [7:0]        FRAME_DROP
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RENDER = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t              state_q;
    logic                pck_q, vs_q;
    logic                pck_rise, vs_rise;
    logic                rd_grant, wr_grant;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                mem_en_q, mem_we_q, ren_ack_q;
    logic [ADDR_W:0]     mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, pix_data_q;
    logic                rd_pend_q, pix_valid_q;
    logic                bank_q, fstart_q;
    logic [7:0]          drop_q;

    assign pck_rise = PCK & ~pck_q;
    assign vs_rise  = VS & ~vs_q;

    // A write is never granted while the previous ACK is visible, so a held
    // request cannot be written twice.
    assign rd_grant = pck_rise & ~ENABLE_MEM;
    assign wr_grant = ~rd_grant & REN_REQ & ~ren_ack_q;

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (vs_rise)
            rd_addr_d = '0;
        else if (rd_grant)
            rd_addr_d = (rd_addr_q == LAST_PIX) ? '0 : rd_addr_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pck_q       <= 1'b0;
            vs_q        <= 1'b0;
            rd_addr_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ren_ack_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            pck_q     <= PCK;
            vs_q      <= VS;
            rd_addr_q <= rd_addr_d;
            mem_en_q  <= rd_grant | wr_grant;
            mem_we_q  <= wr_grant;
            ren_ack_q <= wr_grant;
            if (rd_grant) begin
                mem_addr_q <= {bank_q, rd_addr_q};
            end else if (wr_grant) begin
                mem_addr_q  <= {~bank_q, REN_ADDR};
                mem_wdata_q <= REN_WDATA;
            end
            // RAM data is valid the cycle after the read access.
            rd_pend_q   <= mem_en_q & ~mem_we_q;
            pix_valid_q <= rd_pend_q;
            if (rd_pend_q)
                pix_data_q <= MEM_RDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            bank_q   <= 1'b0;
            fstart_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            fstart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vs_rise)
                        state_q <= START;
                end
                START: begin
                    fstart_q <= 1'b1;
                    state_q  <= RENDER;
                end
                RENDER: begin
                    if (REN_DONE && vs_rise) begin
                        bank_q  <= ~bank_q;
                        state_q <= START;
                    end else if (REN_DONE) begin
                        state_q <= WAIT;
                    end else if (vs_rise && drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end
                WAIT: begin
                    if (vs_rise) begin
                        bank_q  <= ~bank_q;
                        state_q <= START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign REN_ACK     = ren_ack_q;
    assign FRAME_START = fstart_q;
    assign MEM_EN      = mem_en_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign PIX_DATA    = pix_data_q;
    assign PIX_VALID   = pix_valid_q;
    assign DISP_BANK   = bank_q;
    assign FRAME_DROP  = drop_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Directed self-checking bench for vram_scheduler; a 10-pixel frame keeps
// the display-address wrap test short.
module tb_vram_scheduler;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int NPIX   = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic              PCK, ENABLE_MEM, VS, REN_REQ, REN_DONE;
    logic [ADDR_W-1:0] REN_ADDR;
    logic [DATA_W-1:0] REN_WDATA, MEM_RDATA;
    logic              REN_ACK, FRAME_START, MEM_EN, MEM_WE, PIX_VALID, DISP_BANK;
    logic [ADDR_W:0]   MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA, PIX_DATA;
    logic [7:0]        FRAME_DROP;

    int tests = 0;
    int fails = 0;

    vram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
        .CLK(CLK), .RST(RST), .PCK(PCK), .ENABLE_MEM(ENABLE_MEM), .VS(VS),
        .REN_REQ(REN_REQ), .REN_ADDR(REN_ADDR), .REN_WDATA(REN_WDATA),
        .REN_ACK(REN_ACK), .REN_DONE(REN_DONE), .FRAME_START(FRAME_START),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .PIX_DATA(PIX_DATA),
        .PIX_VALID(PIX_VALID), .DISP_BANK(DISP_BANK), .FRAME_DROP(FRAME_DROP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic vs_pulse();
        VS = 1'b1;
        tick(2);
        VS = 1'b0;
        tick(2);
    endtask

    task automatic disp_read(input string tag, input logic [31:0] exp_addr);
        PCK = 1'b1;
        tick(1);
        chk({tag, "_en"}, 32'(MEM_EN), 32'd1);
        chk({tag, "_we"}, 32'(MEM_WE), 32'd0);
        chk({tag, "_addr"}, 32'(MEM_ADDR), exp_addr);
        tick(1);
        PCK = 1'b0;
        tick(2);
    endtask

    initial begin
        RST = 1'b1; PCK = 1'b0; ENABLE_MEM = 1'b0; VS = 1'b0;
        REN_REQ = 1'b0; REN_DONE = 1'b0; REN_ADDR = '0; REN_WDATA = '0;
        MEM_RDATA = 8'h5A;
        tick(3);
        chk("rst_mem_en", 32'(MEM_EN), 32'd0);
        chk("rst_ack", 32'(REN_ACK), 32'd0);
        chk("rst_bank", 32'(DISP_BANK), 32'd0);
        chk("rst_drop", 32'(FRAME_DROP), 32'd0);
        chk("rst_pix_valid", 32'(PIX_VALID), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("idle_no_fstart", 32'(FRAME_START), 32'd0);
        end

        // Display read: rise at N, access at N+1, pixel valid at N+3.
        PCK = 1'b1;
        tick(1);
        chk("rd_en", 32'(MEM_EN), 32'd1);
        chk("rd_we", 32'(MEM_WE), 32'd0);
        chk("rd_addr0", 32'(MEM_ADDR), 32'h0);
        tick(1);
        PCK = 1'b0;
        chk("rd_en_single", 32'(MEM_EN), 32'd0);
        chk("rd_pv_early", 32'(PIX_VALID), 32'd0);
        tick(1);
        chk("rd_pv", 32'(PIX_VALID), 32'd1);
        chk("rd_pix", 32'(PIX_DATA), 32'h5A);
        tick(1);
        chk("rd_pv_pulse", 32'(PIX_VALID), 32'd0);
        disp_read("rd_next", 32'h1);

        // Collision: read wins, write follows, one write despite held request.
        PCK = 1'b1; REN_REQ = 1'b1; REN_ADDR = 19'h100; REN_WDATA = 8'hC3;
        tick(1);
        chk("col_rd_we", 32'(MEM_WE), 32'd0);
        chk("col_rd_addr", 32'(MEM_ADDR), 32'h2);
        chk("col_no_ack", 32'(REN_ACK), 32'd0);
        tick(1);
        PCK = 1'b0;
        chk("col_ack", 32'(REN_ACK), 32'd1);
        chk("col_wr_en", 32'(MEM_EN), 32'd1);
        chk("col_wr_we", 32'(MEM_WE), 32'd1);
        chk("col_wr_addr", 32'(MEM_ADDR), 32'h80100);
        chk("col_wr_data", 32'(MEM_WDATA), 32'hC3);
        tick(1);
        REN_REQ = 1'b0;
        chk("col_ack_once", 32'(REN_ACK), 32'd0);
        chk("col_no_rewrite", 32'(MEM_EN), 32'd0);
        tick(2);

        // Blanking: pixel edge is ignored, write goes straight through.
        ENABLE_MEM = 1'b1; PCK = 1'b1; REN_REQ = 1'b1; REN_ADDR = 19'h5; REN_WDATA = 8'h11;
        tick(1);
        REN_REQ = 1'b0;
        chk("blk_ack", 32'(REN_ACK), 32'd1);
        chk("blk_we", 32'(MEM_WE), 32'd1);
        chk("blk_addr", 32'(MEM_ADDR), 32'h80005);
        tick(1);
        PCK = 1'b0;
        chk("blk_no_read", 32'(MEM_EN), 32'd0);
        tick(2);
        ENABLE_MEM = 1'b0;

        // First VS: IDLE -> START, no swap.
        VS = 1'b1;
        tick(1);
        chk("f1_bank", 32'(DISP_BANK), 32'd0);
        chk("f1_fs_early", 32'(FRAME_START), 32'd0);
        tick(1);
        VS = 1'b0;
        chk("f1_fs", 32'(FRAME_START), 32'd1);
        tick(1);
        chk("f1_fs_pulse", 32'(FRAME_START), 32'd0);
        REN_DONE = 1'b1;
        tick(1);
        REN_DONE = 1'b0;
        tick(1);
        VS = 1'b1;
        tick(1);
        chk("f2_bank", 32'(DISP_BANK), 32'd1);
        chk("f2_fs_early", 32'(FRAME_START), 32'd0);
        tick(1);
        VS = 1'b0;
        chk("f2_fs", 32'(FRAME_START), 32'd1);
        tick(2);
        disp_read("f2_rd", 32'h80000);
        REN_REQ = 1'b1; REN_ADDR = 19'h7; REN_WDATA = 8'h22;
        tick(1);
        REN_REQ = 1'b0;
        chk("f2_wr_ack", 32'(REN_ACK), 32'd1);
        chk("f2_wr_addr", 32'(MEM_ADDR), 32'h7);
        chk("f2_wr_data", 32'(MEM_WDATA), 32'h22);
        tick(2);

        // Overrun: three missed VS, then done and VS together swap without a drop.
        repeat (3) vs_pulse();
        chk("ovr_drop3", 32'(FRAME_DROP), 32'd3);
        chk("ovr_bank", 32'(DISP_BANK), 32'd1);
        REN_DONE = 1'b1; VS = 1'b1;
        tick(1);
        REN_DONE = 1'b0;
        chk("ovr_swap", 32'(DISP_BANK), 32'd0);
        chk("ovr_drop_keep", 32'(FRAME_DROP), 32'd3);
        tick(1);
        VS = 1'b0;
        chk("ovr_fs", 32'(FRAME_START), 32'd1);
        tick(2);

        // Saturation at 255.
        repeat (251) vs_pulse();
        chk("sat_254", 32'(FRAME_DROP), 32'd254);
        vs_pulse();
        chk("sat_255", 32'(FRAME_DROP), 32'd255);
        repeat (48) vs_pulse();
        chk("sat_hold", 32'(FRAME_DROP), 32'd255);
        chk("sat_bank", 32'(DISP_BANK), 32'd0);

        // Display address wraps after NPIX reads.
        for (int i = 0; i < NPIX; i++)
            disp_read("wrap_seq", 32'(i));
        disp_read("wrap_zero", 32'h0);

        // Reset mid-read: outputs clear at once and the pixel is abandoned.
        PCK = 1'b1;
        tick(1);
        chk("mid_rd_en", 32'(MEM_EN), 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_en", 32'(MEM_EN), 32'd0);
        chk("mid_rst_drop", 32'(FRAME_DROP), 32'd0);
        chk("mid_rst_addr", 32'(MEM_ADDR), 32'h0);
        PCK = 1'b0;
        tick(2);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mid_no_pv", 32'(PIX_VALID), 32'd0);
            chk("mid_no_fs", 32'(FRAME_START), 32'd0);
        end

        // REN_DONE in IDLE is ignored: the next frame still reports a drop.
        REN_DONE = 1'b1;
        tick(1);
        REN_DONE = 1'b0;
        tick(1);
        VS = 1'b1;
        tick(2);
        VS = 1'b0;
        chk("post_fs", 32'(FRAME_START), 32'd1);
        tick(2);
        vs_pulse();
        chk("post_drop", 32'(FRAME_DROP), 32'd1);
        chk("post_bank", 32'(DISP_BANK), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
